// File: rtl/mem_dump_reader.sv
// Sweeps a word range through the memory data port and streams each word out
// on a valid/ready channel; read-only, used to dump memory after a run.
module mem_dump_reader #(
  parameter int READ_LATENCY = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_start,
  input  logic [63:0]        io_baseAddr,
  input  logic [COUNT_W-1:0] io_wordCount,
  output logic               io_busy,
  output logic               io_done,
  output logic [63:0]        io_mem_dataAddr,
  output logic               io_mem_writeEn,
  output logic [31:0]        io_mem_writeData,
  output logic [2:0]         io_mem_func3,
  input  logic [31:0]        io_mem_rdata,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [31:0]        io_out_data,
  output logic [63:0]        io_out_addr,
  output logic               io_out_last
);

  localparam int LAT_W = $clog2(READ_LATENCY + 2);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DONE} state_t;

  state_t             state;
  logic [63:0]        cur;
  logic [COUNT_W-1:0] rem;
  logic [LAT_W-1:0]   lat;
  logic               busy_q;
  logic               done_q;
  logic               valid_q;
  logic               last_q;
  logic [63:0]        mem_addr_q;
  logic [31:0]        out_data_q;
  logic [63:0]        out_addr_q;

  assign io_mem_writeEn   = 1'b0;
  assign io_mem_writeData = '0;
  assign io_mem_func3     = 3'b010;

  assign io_busy         = busy_q;
  assign io_done         = done_q;
  assign io_mem_dataAddr = mem_addr_q;
  assign io_out_valid    = valid_q;
  assign io_out_last     = last_q;
  assign io_out_data     = out_data_q;
  assign io_out_addr     = out_addr_q;

  // Outputs are registered alongside the state, so each is set on the edge
  // that enters the state in which it must be visible.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= '0;
      rem        <= '0;
      lat        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      mem_addr_q <= '0;
      out_data_q <= '0;
      out_addr_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (io_start) begin
            cur <= io_baseAddr & ~64'h3;
            rem <= io_wordCount;
            lat <= '0;
            if (io_wordCount == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state      <= REQ;
              busy_q     <= 1'b1;
              mem_addr_q <= io_baseAddr & ~64'h3;
            end
          end
        end
        REQ: begin
          lat <= lat + 1'b1;
          if (lat == LAT_W'(READ_LATENCY)) begin
            out_data_q <= io_mem_rdata;
            out_addr_q <= cur;
            valid_q    <= 1'b1;
            last_q     <= (rem == COUNT_W'(1));
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (io_out_ready) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (rem == COUNT_W'(1)) begin
              state      <= DONE;
              done_q     <= 1'b1;
              busy_q     <= 1'b0;
              mem_addr_q <= '0;
            end else begin
              cur        <= cur + 64'd4;
              rem        <= rem - 1'b1;
              lat        <= '0;
              mem_addr_q <= cur + 64'd4;
              state      <= REQ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader: three lanes with READ_LATENCY 0, 1 and 3,
// each fed by a small latency-accurate memory model.
module tb_mem_dump_reader;

  logic clock;
  logic reset;
  int   cyc;
  int   sel;
  int   n_checks;
  int   n_fail;

  logic        start_a [3];
  logic [63:0] base_a  [3];
  logic [15:0] cnt_a   [3];
  logic        ready_a [3];
  logic        busy_a  [3];
  logic        done_a  [3];
  logic        wen_a   [3];
  logic        valid_a [3];
  logic        last_a  [3];
  logic [63:0] maddr_a [3];
  logic [63:0] oaddr_a [3];
  logic [31:0] wdata_a [3];
  logic [31:0] rdata_a [3];
  logic [31:0] odata_a [3];
  logic [2:0]  f3_a    [3];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h100: mem_word = 32'h1111_1111;
      64'h104: mem_word = 32'h2222_2222;
      64'h108: mem_word = 32'h3333_3333;
      default: mem_word = ~a[31:0];
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lane
    localparam int RL = (g == 0) ? 0 : ((g == 1) ? 1 : 3);

    mem_dump_reader #(.READ_LATENCY(RL), .COUNT_W(16)) u_dut (
      .clock            (clock),
      .reset            (reset),
      .io_start         (start_a[g]),
      .io_baseAddr      (base_a[g]),
      .io_wordCount     (cnt_a[g]),
      .io_busy          (busy_a[g]),
      .io_done          (done_a[g]),
      .io_mem_dataAddr  (maddr_a[g]),
      .io_mem_writeEn   (wen_a[g]),
      .io_mem_writeData (wdata_a[g]),
      .io_mem_func3     (f3_a[g]),
      .io_mem_rdata     (rdata_a[g]),
      .io_out_valid     (valid_a[g]),
      .io_out_ready     (ready_a[g]),
      .io_out_data      (odata_a[g]),
      .io_out_addr      (oaddr_a[g]),
      .io_out_last      (last_a[g])
    );

    if (RL == 0) begin : g_comb
      assign rdata_a[g] = mem_word(maddr_a[g]);
    end else begin : g_pipe
      logic [63:0] aq [RL];
      always @(posedge clock) begin
        aq[0] <= maddr_a[g];
        for (int k = 1; k < RL; k++) aq[k] <= aq[k-1];
      end
      assign rdata_a[g] = mem_word(aq[RL-1]);
    end
  end

  logic        m_valid, m_ready, m_last, m_busy, m_done, m_wen;
  logic [63:0] m_oaddr, m_maddr;
  logic [31:0] m_odata, m_wdata;
  logic [2:0]  m_f3;

  always_comb begin
    m_valid = valid_a[sel];
    m_ready = ready_a[sel];
    m_last  = last_a[sel];
    m_busy  = busy_a[sel];
    m_done  = done_a[sel];
    m_wen   = wen_a[sel];
    m_oaddr = oaddr_a[sel];
    m_maddr = maddr_a[sel];
    m_odata = odata_a[sel];
    m_wdata = wdata_a[sel];
    m_f3    = f3_a[sel];
  end

  logic [63:0] q_addr [$];
  logic [31:0] q_data [$];
  logic        q_last [$];
  int          q_cyc  [$];
  int          done_q [$];
  int          valid_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (!reset) begin
      if (m_valid) valid_q.push_back(cyc);
      if (m_valid && m_ready) begin
        q_addr.push_back(m_oaddr);
        q_data.push_back(m_odata);
        q_last.push_back(m_last);
        q_cyc.push_back(cyc);
      end
      if (m_done) done_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int lane_rl(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 1 : 3);
  endfunction

  task automatic clear_log();
    q_addr.delete();
    q_data.delete();
    q_last.delete();
    q_cyc.delete();
    done_q.delete();
    valid_q.delete();
  endtask

  task automatic start_dump(input logic [63:0] base, input logic [15:0] cnt, output int s);
    @(posedge clock); #1;
    base_a[sel]  = base;
    cnt_a[sel]   = cnt;
    start_a[sel] = 1'b1;
    s = cyc;
    @(posedge clock); #1;
    start_a[sel] = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n0 = done_q.size();
    int i  = 0;
    while (done_q.size() == n0 && i < budget) begin
      @(negedge clock); #1;
      i++;
    end
    check({tag, "_done_seen"}, 64'(done_q.size() > n0), 64'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    int i = 0;
    while (q_addr.size() < n && i < budget) begin
      @(negedge clock); #1;
      i++;
    end
    check({tag, "_beat_seen"}, 64'(q_addr.size() >= n), 64'd1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int i = 0;
    while (!m_valid && i < budget) begin
      @(negedge clock); #1;
      i++;
    end
    check({tag, "_valid_seen"}, 64'(m_valid), 64'd1);
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_busy"},  64'(m_busy),  64'd0);
    check({tag, "_done"},  64'(m_done),  64'd0);
    check({tag, "_valid"}, 64'(m_valid), 64'd0);
    check({tag, "_last"},  64'(m_last),  64'd0);
    check({tag, "_maddr"}, m_maddr,      64'd0);
    check({tag, "_odata"}, 64'(m_odata), 64'd0);
    check({tag, "_oaddr"}, m_oaddr,      64'd0);
    check({tag, "_wen"},   64'(m_wen),   64'd0);
    check({tag, "_wdata"}, 64'(m_wdata), 64'd0);
    check({tag, "_func3"}, 64'(m_f3),    64'd2);
  endtask

  task automatic run_basic(input string tag);
    int s;
    int rl;
    logic [31:0] ed [3];
    ed = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    rl = lane_rl(sel);
    clear_log();
    ready_a[sel] = 1'b1;
    start_dump(64'h100, 16'd3, s);
    wait_done(tag, 80);
    check({tag, "_beats"}, 64'(q_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < q_addr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), q_addr[i], 64'h100 + 64'(4 * i));
        check($sformatf("%s_data%0d", tag, i), 64'(q_data[i]), 64'(ed[i]));
        check($sformatf("%s_last%0d", tag, i), 64'(q_last[i]), 64'(i == 2));
      end
    end
    if (q_cyc.size() == 3) begin
      check({tag, "_first_lat"}, 64'(q_cyc[0] - s), 64'(rl + 2));
      check({tag, "_period1"}, 64'(q_cyc[1] - q_cyc[0]), 64'(rl + 2));
      check({tag, "_period2"}, 64'(q_cyc[2] - q_cyc[1]), 64'(rl + 2));
      if (done_q.size() > 0)
        check({tag, "_done_after_last"}, 64'(done_q[0] - q_cyc[2]), 64'd1);
    end
    repeat (3) @(negedge clock);
    #1;
    check({tag, "_done_pulses"}, 64'(done_q.size()), 64'd1);
    ready_a[sel] = 1'b0;
  endtask

  initial begin
    int s;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    sel      = 1;
    reset    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_a[i] = 1'b0;
      base_a[i]  = '0;
      cnt_a[i]   = '0;
      ready_a[i] = 1'b0;
    end
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) begin
      sel = i;
      #1;
      idle_checks($sformatf("reset_l%0d", i));
    end
    reset = 1'b0;
    sel   = 1;
    repeat (2) @(posedge clock);

    run_basic("basic");

    // Backpressure on beat 2
    clear_log();
    ready_a[sel] = 1'b1;
    start_dump(64'h100, 16'd3, s);
    wait_beats("bp_b1", 1, 30);
    @(posedge clock); #1;
    ready_a[sel] = 1'b0;
    wait_valid("bp_b2", 30);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp_valid%0d", k), 64'(m_valid), 64'd1);
      check($sformatf("bp_oaddr%0d", k), m_oaddr, 64'h104);
      check($sformatf("bp_odata%0d", k), 64'(m_odata), 64'h2222_2222);
      check($sformatf("bp_maddr%0d", k), m_maddr, 64'h104);
      if (k < 4) @(negedge clock);
    end
    @(posedge clock); #1;
    ready_a[sel] = 1'b1;
    wait_done("bp", 60);
    check("bp_beats", 64'(q_addr.size()), 64'd3);
    if (q_addr.size() == 3) begin
      check("bp_addr1", q_addr[1], 64'h104);
      check("bp_data1", 64'(q_data[1]), 64'h2222_2222);
      check("bp_addr2", q_addr[2], 64'h108);
      check("bp_data2", 64'(q_data[2]), 64'h3333_3333);
    end
    ready_a[sel] = 1'b0;
    repeat (2) @(posedge clock);

    // Zero count
    clear_log();
    ready_a[sel] = 1'b1;
    start_dump(64'h100, 16'd0, s);
    @(negedge clock);
    check("zero_done", 64'(m_done), 64'd1);
    check("zero_busy", 64'(m_busy), 64'd0);
    repeat (3) @(negedge clock);
    #1;
    check("zero_done_pulses", 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check("zero_done_cycle", 64'(done_q[0] - s), 64'd1);
    check("zero_no_valid", 64'(valid_q.size()), 64'd0);

    // Misaligned base
    clear_log();
    start_dump(64'h103, 16'd1, s);
    wait_done("mis", 30);
    check("mis_beats", 64'(q_addr.size()), 64'd1);
    if (q_addr.size() == 1) begin
      check("mis_addr", q_addr[0], 64'h100);
      check("mis_data", 64'(q_data[0]), 64'h1111_1111);
      check("mis_last", 64'(q_last[0]), 64'd1);
    end

    // Address wrap with a start pulse while busy
    clear_log();
    start_dump(64'hFFFF_FFFF_FFFF_FFFC, 16'd2, s);
    wait_beats("wrap_b1", 1, 30);
    @(posedge clock); #1;
    base_a[sel]  = 64'h100;
    cnt_a[sel]   = 16'd3;
    start_a[sel] = 1'b1;
    @(posedge clock); #1;
    start_a[sel] = 1'b0;
    wait_done("wrap", 40);
    repeat (12) @(negedge clock);
    #1;
    check("wrap_beats", 64'(q_addr.size()), 64'd2);
    check("wrap_done_pulses", 64'(done_q.size()), 64'd1);
    if (q_addr.size() == 2) begin
      check("wrap_addr0", q_addr[0], 64'hFFFF_FFFF_FFFF_FFFC);
      check("wrap_data0", 64'(q_data[0]), 64'h0000_0003);
      check("wrap_last0", 64'(q_last[0]), 64'd0);
      check("wrap_addr1", q_addr[1], 64'h0);
      check("wrap_data1", 64'(q_data[1]), 64'hFFFF_FFFF);
      check("wrap_last1", 64'(q_last[1]), 64'd1);
    end

    // Asynchronous reset during HOLD of beat 1
    clear_log();
    ready_a[sel] = 1'b0;
    start_dump(64'h100, 16'd4, s);
    wait_valid("rst", 30);
    #2;
    reset = 1'b1;
    #1;
    idle_checks("rst_async");
    @(posedge clock); #2;
    reset = 1'b0;
    ready_a[sel] = 1'b1;
    repeat (6) @(negedge clock);
    #1;
    check("rst_no_done", 64'(done_q.size()), 64'd0);
    check("rst_no_beats", 64'(q_addr.size()), 64'd0);
    start_dump(64'h200, 16'd1, s);
    wait_done("rst_fresh", 30);
    check("rst_fresh_beats", 64'(q_addr.size()), 64'd1);
    if (q_addr.size() == 1) begin
      check("rst_fresh_addr", q_addr[0], 64'h200);
      check("rst_fresh_data", 64'(q_data[0]), 64'hFFFF_FDFF);
    end
    ready_a[sel] = 1'b0;

    // Latency sweep
    sel = 0;
    run_basic("lat0");
    sel = 2;
    run_basic("lat3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
